// File: rtl/rgb_window_3x3.sv
// rgb_window_3x3
//   Front end of the highlight-suppression filter. Two line buffers per RGB888
//   pixel (R, G and B packed into one RAM word) feed a 3x3 column shift window.
//   The 3x3 neighbourhood is border-replicated, and the frame syncs are delayed
//   so that they line up with it.
//   Latency: two register stages (input/RAM-read stage, window stage).
// Ports
//   clk, rst                      pixel clock, synchronous active-high reset
//   per_frame_vsync/hsync/href    input syncs and pixel valid
//   per_img_red/green/blue        input pixel
//   matrix_red/green/blue         3x3 windows {p11..p33}, p11 in the MSBs, 0 when href out is 0
//   matrix_frame_vsync/hsync/href syncs delayed 2 clk (href only while a frame is active)
//   line_overflow                 sticky per frame: some line ran past IMG_WIDTH pixels
module rgb_window_3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 1280,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    per_frame_vsync,
  input  logic                    per_frame_hsync,
  input  logic                    per_frame_href,
  input  logic [DATA_WIDTH-1:0]   per_img_red,
  input  logic [DATA_WIDTH-1:0]   per_img_green,
  input  logic [DATA_WIDTH-1:0]   per_img_blue,
  output logic [9*DATA_WIDTH-1:0] matrix_red,
  output logic [9*DATA_WIDTH-1:0] matrix_green,
  output logic [9*DATA_WIDTH-1:0] matrix_blue,
  output logic                    matrix_frame_vsync,
  output logic                    matrix_frame_hsync,
  output logic                    matrix_frame_href,
  output logic                    line_overflow
);

  localparam int PW  = 3 * DATA_WIDTH;
  localparam int RAW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] COL_MAX = '1;

  typedef enum logic {WAIT_FRAME, ACTIVE} state_t;

  state_t state_q, state_d;
  logic                  vs_prev_q, vs_prev_d;
  logic                  href_prev_q, href_prev_d;
  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic [1:0]            row_q, row_d;

  // Stage 1: sampled pixel plus its coordinates; RAM read data lands alongside.
  logic           vs1_q, vs1_d, hs1_q, hs1_d, href1_q, href1_d;
  logic [PW-1:0]  pix1_q, pix1_d;
  logic [1:0]     xc1_q, xc1_d;       // 0: x==0, 1: x==1, 2: x>=2
  logic [1:0]     y1_q, y1_d;         // saturated row
  logic           ovf1_q, ovf1_d, we1_q, we1_d, vsr1_q, vsr1_d;
  logic [RAW-1:0] waddr1_q, waddr1_d;
  logic           byp1_q, byp1_d;
  logic [PW-1:0]  bypd1_q, bypd1_d;

  // Stage 2: window registers drive the outputs directly. win[col][row], col 2 = newest.
  logic                      vs2_q, vs2_d, hs2_q, hs2_d, href2_q, href2_d;
  logic                      lo_q, lo_d;
  logic [2:0][2:0][PW-1:0]   win_q, win_d;

  logic [PW-1:0] lb1_mem [IMG_WIDTH];
  logic [PW-1:0] lb2_mem [IMG_WIDTH];
  logic [PW-1:0] lb1_rd_q, lb2_rd_q;

  logic                  vs_rise, active, href_fall, pix_ok, ovf0, we0;
  logic [ADDR_WIDTH-1:0] x0;
  logic [1:0]            y0;
  logic [RAW-1:0]        raddr;
  logic [PW-1:0]         lb2_data;
  logic [2:0][PW-1:0]    cur;

  // ---------------- stage 0: sync edges, counters, RAM addressing ----------------
  always_comb begin
    vs_rise   = per_frame_vsync & ~vs_prev_q;
    active    = (state_q == ACTIVE) | vs_rise;
    href_fall = href_prev_q & ~per_frame_href;
    // A vsync rise takes precedence: the coincident pixel is (0,0).
    x0        = vs_rise ? '0 : col_q;
    y0        = vs_rise ? 2'd0 : row_q;
    pix_ok    = per_frame_href & active;
    ovf0      = pix_ok & (32'(x0) >= IMG_WIDTH);
    we0       = pix_ok & ~ovf0;
    raddr     = ovf0 ? '0 : x0[RAW-1:0];

    state_d     = vs_rise ? ACTIVE : state_q;
    vs_prev_d   = per_frame_vsync;
    href_prev_d = per_frame_href;
    col_d       = col_q;
    row_d       = row_q;
    if (active) begin
      if (pix_ok)                   col_d = (x0 == COL_MAX) ? x0 : x0 + ADDR_WIDTH'(1);
      else if (vs_rise | href_fall) col_d = '0;
      if (vs_rise)                          row_d = 2'd0;
      else if (href_fall && row_q != 2'd2)  row_d = row_q + 2'd1;
    end

    vs1_d    = per_frame_vsync;
    hs1_d    = per_frame_hsync;
    href1_d  = pix_ok;
    pix1_d   = {per_img_red, per_img_green, per_img_blue};
    xc1_d    = (x0 == '0) ? 2'd0 : (x0 == ADDR_WIDTH'(1)) ? 2'd1 : 2'd2;
    y1_d     = y0;
    ovf1_d   = ovf0;
    we1_d    = we0;
    waddr1_d = raddr;
    vsr1_d   = vs_rise;
    // LB2 is written one cycle after LB1 (it needs LB1's old word); forward that
    // word if this cycle reads the same LB2 address (one-pixel lines).
    byp1_d   = we1_q & (waddr1_q == raddr);
    bypd1_d  = lb1_rd_q;
  end

  // Line buffers: synchronous read, old data returned on a same-address write.
  always_ff @(posedge clk) begin
    if (we0)   lb1_mem[raddr]    <= pix1_d;
    if (we1_q) lb2_mem[waddr1_q] <= lb1_rd_q;
    lb1_rd_q <= lb1_mem[raddr];
    lb2_rd_q <= lb2_mem[raddr];
  end

  // ---------------- stage 1: assemble the current column, shift the window ----------------
  always_comb begin
    lb2_data = byp1_q ? bypd1_q : lb2_rd_q;
    cur[2]   = pix1_q;
    // Overflow pixels have no stored history; their upper rows are forced to 0.
    cur[1]   = ovf1_q ? '0 : (y1_q == 2'd0) ? pix1_q : lb1_rd_q;
    cur[0]   = ovf1_q ? '0 : (y1_q == 2'd0) ? pix1_q :
               (y1_q == 2'd1) ? lb1_rd_q : lb2_data;

    win_d = '0;
    if (href1_q) begin
      win_d[2] = cur;
      win_d[1] = (xc1_q == 2'd0) ? cur : win_q[2];
      win_d[0] = (xc1_q == 2'd0) ? cur : (xc1_q == 2'd1) ? win_q[2] : win_q[1];
    end

    vs2_d   = vs1_q;
    hs2_d   = hs1_q;
    href2_d = href1_q;
    // Clear aligned with the delayed vsync rise so the flag tracks the window stream.
    lo_d    = vsr1_q ? ovf1_q : (lo_q | ovf1_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_FRAME;
      vs_prev_q   <= 1'b0;
      href_prev_q <= 1'b0;
      col_q       <= '0;
      row_q       <= 2'd0;
      vs1_q       <= 1'b0;
      hs1_q       <= 1'b0;
      href1_q     <= 1'b0;
      pix1_q      <= '0;
      xc1_q       <= 2'd0;
      y1_q        <= 2'd0;
      ovf1_q      <= 1'b0;
      we1_q       <= 1'b0;
      waddr1_q    <= '0;
      vsr1_q      <= 1'b0;
      byp1_q      <= 1'b0;
      bypd1_q     <= '0;
      vs2_q       <= 1'b0;
      hs2_q       <= 1'b0;
      href2_q     <= 1'b0;
      lo_q        <= 1'b0;
      win_q       <= '0;
    end else begin
      state_q     <= state_d;
      vs_prev_q   <= vs_prev_d;
      href_prev_q <= href_prev_d;
      col_q       <= col_d;
      row_q       <= row_d;
      vs1_q       <= vs1_d;
      hs1_q       <= hs1_d;
      href1_q     <= href1_d;
      pix1_q      <= pix1_d;
      xc1_q       <= xc1_d;
      y1_q        <= y1_d;
      ovf1_q      <= ovf1_d;
      we1_q       <= we1_d;
      waddr1_q    <= waddr1_d;
      vsr1_q      <= vsr1_d;
      byp1_q      <= byp1_d;
      bypd1_q     <= bypd1_d;
      vs2_q       <= vs2_d;
      hs2_q       <= hs2_d;
      href2_q     <= href2_d;
      lo_q        <= lo_d;
      win_q       <= win_d;
    end
  end

  // ---------------- outputs ----------------
  assign matrix_frame_vsync = vs2_q;
  assign matrix_frame_hsync = hs2_q;
  assign matrix_frame_href  = href2_q;
  assign line_overflow      = lo_q;

  // Tap k = 3*row + col goes to slot 8-k so p11 lands in the MSBs.
  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      localparam int K = 8 - (r * 3 + c);
      assign matrix_red  [K*DATA_WIDTH +: DATA_WIDTH] = win_q[c][r][2*DATA_WIDTH +: DATA_WIDTH];
      assign matrix_green[K*DATA_WIDTH +: DATA_WIDTH] = win_q[c][r][DATA_WIDTH +: DATA_WIDTH];
      assign matrix_blue [K*DATA_WIDTH +: DATA_WIDTH] = win_q[c][r][0 +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_rgb_window_3x3.sv
// Testbench for rgb_window_3x3 (IMG_WIDTH=8, ADDR_WIDTH=4). A frame-level model
// keeps received lines in a 2D image and derives each 3x3 window from image
// coordinates with clamping; outputs are compared two clocks after each sample.
module tb_rgb_window_3x3;
  localparam int DW = 8, W = 8, AW = 4;

  logic clk = 1'b0;
  logic rst, vsync, hsync, href;
  logic [DW-1:0] red, green, blue;
  logic [9*DW-1:0] matrix_red, matrix_green, matrix_blue;
  logic mvs, mhs, mhref, lovf;

  rgb_window_3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .per_frame_vsync(vsync), .per_frame_hsync(hsync), .per_frame_href(href),
    .per_img_red(red), .per_img_green(green), .per_img_blue(blue),
    .matrix_red(matrix_red), .matrix_green(matrix_green), .matrix_blue(matrix_blue),
    .matrix_frame_vsync(mvs), .matrix_frame_hsync(mhs), .matrix_frame_href(mhref),
    .line_overflow(lovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic vs, hs, hr, lo;
    logic [71:0] mr, mg, mb;
    logic cw;
  } exp_t;

  exp_t eq[$];
  int checks = 0, errors = 0;
  bit chk_win = 1'b1;
  bit rec_on  = 1'b0;
  logic [215:0] rec[$], rec_a[$];

  // model state
  bit m_act, m_vsp, m_hrp, m_ovf;
  int m_x, m_y;
  logic [23:0] img [16][16];
  logic [23:0] src [16][16];

  function automatic logic [23:0] tap(int ln, int cl, int rr);
    if (rr < 2 && cl >= W) return 24'h0;
    if (ln > 15) ln = 15;
    if (cl > 15) cl = 15;
    return img[ln][cl];
  endfunction

  task automatic chk(input string tag, input logic [215:0] got, input logic [215:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step(input bit rs, input bit vs, input bit hs, input bit hr, input logic [23:0] px);
    exp_t e;
    bit rise, act, fall;
    int ln, cl, k;
    logic [23:0] t;
    rst = rs; vsync = vs; hsync = hs; href = hr; {red, green, blue} = px;
    e = '0;
    if (rs) begin
      m_act = 0; m_vsp = 0; m_hrp = 0; m_ovf = 0; m_x = 0; m_y = 0;
      e.cw = 1'b1;
      eq.delete();
      eq.push_back(e);
      eq.push_back(e);
    end else begin
      rise = vs && !m_vsp;
      act  = m_act || rise;
      fall = m_hrp && !hr;
      if (act && fall) begin m_x = 0; m_y++; end
      if (rise) begin m_x = 0; m_y = 0; m_ovf = 0; end
      e.vs = vs; e.hs = hs; e.hr = act && hr; e.cw = chk_win;
      if (act && hr) begin
        img[(m_y > 15) ? 15 : m_y][m_x] = px;
        if (m_x >= W) m_ovf = 1;
        if (chk_win) begin
          for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++) begin
              ln = m_y - (((2 - rr) < m_y) ? (2 - rr) : m_y);
              cl = m_x - (((2 - cc) < m_x) ? (2 - cc) : m_x);
              t  = tap(ln, cl, rr);
              k  = 8 - (rr * 3 + cc);
              e.mr[k*8 +: 8] = t[23:16];
              e.mg[k*8 +: 8] = t[15:8];
              e.mb[k*8 +: 8] = t[7:0];
            end
        end
        m_x = (m_x < 15) ? m_x + 1 : 15;
      end
      e.lo = m_ovf;
      m_act = act; m_vsp = vs; m_hrp = hr;
      eq.push_back(e);
    end
    @(posedge clk); #1;
    if (eq.size() >= 2) begin
      e = eq.pop_front();
      chk("sync", 216'({mvs, mhs, mhref, lovf}), 216'({e.vs, e.hs, e.hr, e.lo}));
      if (e.cw) chk("window", {matrix_red, matrix_green, matrix_blue}, {e.mr, e.mg, e.mb});
      if (rec_on && mhref) rec.push_back({matrix_red, matrix_green, matrix_blue});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0, 24'h0);
  endtask

  task automatic vpulse();
    step(0, 1, 0, 0, 24'h0);
  endtask

  task automatic send_line(input int y, input int n, input int gap);
    for (int x = 0; x < n; x++) step(0, 0, 0, 1, src[y][x]);
    idle(gap);
  endtask

  task automatic rand_src();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) src[y][x] = 24'($urandom);
  endtask

  initial begin
    step(1, 0, 0, 0, 24'h0);
    step(1, 0, 0, 0, 24'h0);
    chk("reset_out", 216'({mvs, mhs, mhref, lovf, matrix_red, matrix_green, matrix_blue}), 216'h0);
    idle(3);

    // 1: ramp 4x4
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) src[y][x] = {3{8'(16 * y + x)}};
    vpulse(); idle(2);
    send_line(0, 4, 3);
    send_line(1, 4, 3);
    for (int x = 0; x < 4; x++) step(0, 0, 0, 1, src[2][x]);
    chk("ramp22", {matrix_red, matrix_green, matrix_blue}, {3{72'h000102101112202122}});
    idle(3);
    send_line(3, 4, 3);

    // 2: first-pixel replication
    src[0][0] = {3{8'h55}}; src[0][1] = {3{8'h66}}; src[0][2] = {3{8'h77}};
    vpulse(); idle(1);
    step(0, 0, 0, 1, src[0][0]);
    step(0, 0, 0, 1, src[0][1]);
    chk("first00", {matrix_red, matrix_green, matrix_blue}, {27{8'h55}});
    step(0, 0, 0, 1, src[0][2]);
    chk("first01", {matrix_red, matrix_green, matrix_blue}, {9{24'h555566}});
    idle(2);

    // 3: random sync toggling
    chk_win = 1'b0;
    for (int i = 0; i < 300; i++)
      step(0, $urandom_range(0, 9) == 0, 1'($urandom), $urandom_range(0, 9) < 7, 24'($urandom));
    idle(2);
    chk_win = 1'b1;

    // 4: reset mid row 3, then replicated row 0 on the next frame
    rand_src();
    vpulse(); idle(1);
    for (int y = 0; y < 3; y++) send_line(y, 6, 2);
    step(0, 0, 0, 1, src[3][0]);
    step(0, 0, 0, 1, src[3][1]);
    step(1, 0, 0, 1, src[3][2]);
    chk("rst_mid", 216'({mvs, mhs, mhref, lovf, matrix_red, matrix_green, matrix_blue}), 216'h0);
    for (int x = 3; x < 6; x++) step(0, 0, 0, 1, src[3][x]);
    chk("href_wait", 216'(mhref), 216'h0);
    idle(2);
    send_line(4, 6, 2);
    rand_src();
    vpulse(); idle(1);
    for (int y = 0; y < 3; y++) send_line(y, 6, 2);

    // 5: overflow
    rand_src();
    vpulse(); idle(1);
    for (int x = 0; x < 9; x++) step(0, 0, 0, 1, src[0][x]);
    chk("ovf_before", 216'(lovf), 216'h0);
    step(0, 0, 0, 1, src[0][9]);
    chk("ovf_set", 216'(lovf), 216'h1);
    idle(2);
    send_line(1, 10, 2);
    chk("ovf_hold", 216'(lovf), 216'h1);
    vpulse(); idle(1);
    chk("ovf_clear", 216'(lovf), 216'h0);
    idle(1);

    // 6: same 8x6 frame, minimal vs long blanking
    rand_src();
    rec.delete(); rec_on = 1'b1;
    step(0, 1, 0, 1, src[0][0]);
    for (int x = 1; x < 8; x++) step(0, 0, 0, 1, src[0][x]);
    idle(1);
    for (int y = 1; y < 6; y++) send_line(y, 8, 1);
    rec_a = rec;
    rec.delete();
    vpulse(); idle(100);
    for (int y = 0; y < 6; y++) send_line(y, 8, 100);
    rec_on = 1'b0;
    chk("blank_len", 216'(rec.size()), 216'(rec_a.size()));
    chk("blank_cnt", 216'(rec.size()), 216'd48);
    for (int i = 0; i < rec.size() && i < rec_a.size(); i++)
      chk("blank_win", rec[i], rec_a[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
